thread_timer: RTL and testbench
===============================

// Module: thread_timer
// PURPOSE
//  Barrel-thread scheduler feeding register_file. Picks the issuing hardware thread each cycle
//  (thread_rs_id, used for operand reads). Carries each issued thread id down a fixed-latency
//  delay line so thread_rd_id arrives aligned with the writeback of that thread's instruction.
// PARAMETERS
//  NUM_THREADS  4  hardware threads; power of 2, >=2; TID_W = $clog2(NUM_THREADS)
//  WB_LATENCY   3  cycles from issue to writeback; >=1
// PORTS
//  clk            in   1      core clock
//  rst            in   1      asynchronous, active-low reset
//  thread_active  in   NUM_THREADS  per-thread run enable
//  issue_stall    in   1      hold current issue slot (downstream back-pressure)
//  flush          in   1      kill all in-flight writeback slots
//  issue_valid    out  1      thread_rs_id names a thread that is issuing/holding
//  thread_rs_id   out  TID_W  thread id for register_file operand reads
//  wb_valid       out  1      writeback slot holds a live issued instruction
//  thread_rd_id   out  TID_W  thread id for register_file write port
// BEHAVIOUR
//  - Reset (rst low, async): issue_valid=0, thread_rs_id=0, wb_valid=0, thread_rd_id=0, delay line valids/ids=0.
//  - issue event = issue_valid & ~issue_stall (sampled at posedge).
//  - Selection, registered, every posedge unless (issue_valid & issue_stall):
//    base = issue_valid ? thread_rs_id+1 : 0 (mod NUM_THREADS);
//    search base, base+1, ... wrapping; first thread with thread_active=1 wins.
//    found -> thread_rs_id<=winner, issue_valid<=1; none -> issue_valid<=0, thread_rs_id holds.
//  - Stall: thread_rs_id and issue_valid frozen, regardless of thread_active changes.
//  - Single active thread: re-selected every cycle (search wraps back to itself).
//  - Thread deactivated while selected and not stalled: skipped at next edge; issue in progress completes.
//  - Delay line: WB_LATENCY stages of {valid,id}; stage0 <= {issue event, thread_rs_id};
//    stage k <= stage k-1. wb_valid/thread_rd_id = last stage. Stalled cycles insert bubbles (valid=0).
//  - Issue at edge N -> wb_valid=1 with matching thread_rd_id during cycle after edge N+WB_LATENCY-1.
//  - flush: all stage valids cleared at next edge (ids don't care); an issue event in the same cycle
//    is also dropped. Selection logic unaffected by flush.
//  - wb_valid=0 -> thread_rd_id is don't-care for consumers but must be stable (no X).
// CONFIGURATION
//  THREAD_TIMER_PERF_EN defined: adds ports perf_sel in TID_W, perf_count out 32;
//    per-thread 32-bit counters increment on each issue event for that thread, wrap at 2^32-1 -> 0,
//    reset to 0; perf_count = counter[perf_sel] combinationally.
//  Undefined: no counters, no perf ports; all other behaviour identical.
// TESTING
//  1. thread_active=4'b1111, no stall -> thread_rs_id 0,1,2,3,0..; thread_rd_id same sequence 3 cycles later.
//  2. thread_active=4'b0101 -> thread_rs_id 0,2,0,2; 1,3 never issued; wb ids 0,2 in order.
//  3. all active, issue_stall high 2 cycles at id=1 -> id 1 held 3 cycles; 2 bubbles (wb_valid=0) at writeback.
//  4. thread_active=0 -> issue_valid=0, wb_valid=0 after WB_LATENCY; set 4'b1000 -> next edge id=3, repeats.
//  5. flush with 3 slots in flight -> wb_valid=0 for next 3 cycles, then resumes with post-flush issues.
//  6. rst low mid-stream -> all outputs 0 immediately (async); PERF_EN: thread 2 issued 5 times -> perf_sel=2 reads 5.

Source files
------------

// File: rtl/thread_timer.sv
// thread_timer: barrel-thread issue scheduler with a writeback-aligned id delay line.
// Optional per-thread issue counters when THREAD_TIMER_PERF_EN is defined.
//   clk, rst        : core clock, async active-low reset
//   thread_active   : per-thread run enable
//   issue_stall     : hold the current issue slot
//   flush           : kill all in-flight writeback slots
//   issue_valid     : thread_rs_id is issuing/holding
//   thread_rs_id    : operand-read thread id
//   wb_valid        : writeback slot is live
//   thread_rd_id    : write-port thread id
//   perf_sel/count  : (THREAD_TIMER_PERF_EN) counter select / value
module thread_timer #(
  parameter  int NUM_THREADS = 4,
  parameter  int WB_LATENCY  = 3,
  localparam int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_active,
  input  logic                   issue_stall,
  input  logic                   flush,
  output logic                   issue_valid,
  output logic [TID_W-1:0]       thread_rs_id,
  output logic                   wb_valid,
  output logic [TID_W-1:0]       thread_rd_id
`ifdef THREAD_TIMER_PERF_EN
  ,
  input  logic [TID_W-1:0]       perf_sel,
  output logic [31:0]            perf_count
`endif
);

  logic             hold;
  logic             issue_ev;
  logic [TID_W-1:0] base;
  logic [TID_W-1:0] cand;
  logic [TID_W-1:0] winner;
  logic             found;

  logic [WB_LATENCY-1:0] vld;
  logic [TID_W-1:0]      ids [WB_LATENCY];

  assign hold     = issue_valid & issue_stall;
  assign issue_ev = issue_valid & ~issue_stall;

  // Round-robin search starting after the current thread;
  // id arithmetic wraps for free since NUM_THREADS is 2^TID_W.
  always_comb begin
    base   = issue_valid ? thread_rs_id + TID_W'(1) : '0;
    cand   = '0;
    winner = thread_rs_id;
    found  = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cand = base + TID_W'(i);
      if (!found && thread_active[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid  <= 1'b0;
      thread_rs_id <= '0;
    end else if (!hold) begin
      issue_valid <= found;
      if (found) thread_rs_id <= winner;
    end
  end

  // Ids shift unconditionally so thread_rd_id never goes X;
  // only the valids are cleared by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int k = 0; k < WB_LATENCY; k++) ids[k] <= '0;
    end else begin
      vld[0] <= issue_ev & ~flush;
      ids[0] <= thread_rs_id;
      for (int k = 1; k < WB_LATENCY; k++) begin
        vld[k] <= vld[k-1] & ~flush;
        ids[k] <= ids[k-1];
      end
    end
  end

  assign wb_valid     = vld[WB_LATENCY-1];
  assign thread_rd_id = ids[WB_LATENCY-1];

`ifdef THREAD_TIMER_PERF_EN
  logic [31:0] perf_cnt [NUM_THREADS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NUM_THREADS; t++) perf_cnt[t] <= '0;
    end else if (issue_ev) begin
      perf_cnt[thread_rs_id] <= perf_cnt[thread_rs_id] + 32'd1;
    end
  end

  assign perf_count = perf_cnt[perf_sel];
`else
  // No per-thread issue counters in this build.
`endif

endmodule

// File: tb/tb_thread_timer.sv
// tb_thread_timer: directed vectors for thread_timer.
// Expected ids are hand-computed per edge; rd ids are the expected rs ids 3 edges earlier.
module tb_thread_timer;

  localparam int NT = 4;
  localparam int TW = 2;

  logic          clk;
  logic          rst;
  logic [NT-1:0] thread_active;
  logic          issue_stall;
  logic          flush;
  logic          issue_valid;
  logic [TW-1:0] thread_rs_id;
  logic          wb_valid;
  logic [TW-1:0] thread_rd_id;
`ifdef THREAD_TIMER_PERF_EN
  logic [TW-1:0] perf_sel;
  logic [31:0]   perf_count;
`endif

  thread_timer #(
    .NUM_THREADS(NT),
    .WB_LATENCY (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .thread_active(thread_active),
    .issue_stall  (issue_stall),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .thread_rs_id (thread_rs_id),
    .wb_valid     (wb_valid),
    .thread_rd_id (thread_rd_id)
`ifdef THREAD_TIMER_PERF_EN
    ,
    .perf_sel     (perf_sel),
    .perf_count   (perf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int e    = 0;
  int hist [0:127];

  task automatic check(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare outputs against expectations.
  task automatic cyc(input int ers, input int eiv, input int ewb);
    @(posedge clk);
    #1;
    e++;
    hist[e] = ers;
    check($sformatf("iv@%0d", e), int'(issue_valid), eiv);
    check($sformatf("rs@%0d", e), int'(thread_rs_id), ers);
    check($sformatf("wb@%0d", e), int'(wb_valid), ewb);
    if (ewb != 0 && e > 3)
      check($sformatf("rd@%0d", e), int'(thread_rd_id), hist[e-3]);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) hist[i] = 0;
    rst           = 1'b0;
    thread_active = '0;
    issue_stall   = 1'b0;
    flush         = 1'b0;
`ifdef THREAD_TIMER_PERF_EN
    perf_sel = '0;
`endif
    #2;
    check("rst_iv", int'(issue_valid), 0);
    check("rst_rs", int'(thread_rs_id), 0);
    check("rst_wb", int'(wb_valid), 0);
    check("rst_rd", int'(thread_rd_id), 0);
    @(posedge clk);
    #2;
    rst           = 1'b1;
    thread_active = 4'b1111;

    // all active: 0,1,2,3,... ; wb 3 edges later
    for (int k = 1; k <= 12; k++) cyc((k - 1) % 4, 1, (k >= 4) ? 1 : 0);

    // 0101: alternate 0,2
    thread_active = 4'b0101;
    for (int k = 13; k <= 20; k++) cyc(((k - 13) % 2) * 2, 1, 1);

    // stall 2 cycles while id 1 is selected
    thread_active = 4'b1111;
    cyc(3, 1, 1);
    cyc(0, 1, 1);
    cyc(1, 1, 1);
    issue_stall = 1'b1;
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    issue_stall = 1'b0;
    cyc(2, 1, 0);
    cyc(3, 1, 0);
    cyc(0, 1, 1);
    cyc(1, 1, 1);

    // no thread active, then only thread 3
    thread_active = 4'b0000;
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    thread_active = 4'b1000;
    cyc(3, 1, 0);
    cyc(3, 1, 0);
    cyc(3, 1, 0);
    cyc(3, 1, 1);
    cyc(3, 1, 1);

    // flush with three slots in flight
    thread_active = 4'b1111;
    cyc(0, 1, 1);
    cyc(1, 1, 1);
    cyc(2, 1, 1);
    flush = 1'b1;
    cyc(3, 1, 0);
    flush = 1'b0;
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(2, 1, 1);
    cyc(3, 1, 1);

    // async reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    check("arst_iv", int'(issue_valid), 0);
    check("arst_rs", int'(thread_rs_id), 0);
    check("arst_wb", int'(wb_valid), 0);
    check("arst_rd", int'(thread_rd_id), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    e   = 0;
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(2, 1, 0);
    cyc(3, 1, 1);

`ifdef THREAD_TIMER_PERF_EN
    // thread 2 alone: issues at edges 2..6 of this run
    #1;
    rst = 1'b0;
    #1;
    check("perf_rst", int'(perf_count), 0);
    thread_active = 4'b0100;
    perf_sel      = 2'd2;
    @(posedge clk);
    #2;
    rst = 1'b1;
    e   = 0;
    for (int k = 1; k <= 5; k++) cyc(2, 1, (k >= 4) ? 1 : 0);
    thread_active = 4'b0000;
    cyc(2, 0, 1);
    check("perf_t2", int'(perf_count), 5);
    perf_sel = 2'd1;
    #1;
    check("perf_t1", int'(perf_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
